mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single unified memory port of the pipelined RV32I core between the instruction-fetch stage (IF) and the data-memory stage (DM). Accepts one outstanding request per requester and issues at most one memory transaction at a time. Tolerates variable memory latency and drives per-stage stall signals that gate the pipeline-register enables. DM has fixed priority, with a starvation guard that forces an IF grant after a bounded run of DM grants.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are DATA_W/8 wide.
- `STARVE_LIM`, default 4: maximum consecutive DM grants while IF is waiting; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_valid`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetch data; meaningful only while `if_valid`.
- `if_valid` out 1: fetch-complete pulse.
- `if_stall` out 1: IF must hold.
- `dm_req` in 1: data request; held with `dm_we`, `dm_be`, `dm_addr`, `dm_wdata` until `dm_valid`.
- `dm_we` in 1: write when 1.
- `dm_be` in DATA_W/8: byte enables.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: write data.
- `dm_rdata` out DATA_W: load data; meaningful only while `dm_valid` and `!dm_we`.
- `dm_valid` out 1: data-complete pulse.
- `dm_stall` out 1: DM must hold.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: memory write.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ack` in 1: single-cycle completion from memory; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: memory read data.
- `err_ack` out 1: sticky flag, set by an ack that arrives with no transaction outstanding.

## Operation
- FSM states: `IDLE`, `BUSY_IF`, `BUSY_DM`.
- **IDLE** arbitration, in priority order:
  - `dm_req` and starvation count < STARVE_LIM: go to `BUSY_DM`.
  - else `if_req`: go to `BUSY_IF`.
  - else stay in `IDLE`.
  - When both requests are present and the count equals STARVE_LIM, IF wins.
- On a grant, latch the winner's request fields into the `mem_*` registers and set `mem_req`. The `mem_*` outputs stay stable until the ack.
- **BUSY_x**: wait for `mem_ack`.
  - On ack: `x_valid` = 1 combinationally, `x_rdata` = `mem_rdata` (pass-through), `mem_req` is cleared at the clock edge, and the FSM returns to `IDLE`.
  - A write still completes with `dm_valid`.
- Stall outputs, combinational: `if_stall = if_req & ~if_valid`, `dm_stall = dm_req & ~dm_valid`.
- Starvation counter, width `$clog2(STARVE_LIM+1)`:
  - Increments on a DM grant while `if_req` = 1, saturating at STARVE_LIM.
  - Clears on an IF grant, or on a DM grant while `if_req` = 0.
- `mem_ack` in `IDLE` is ignored for data purposes and sets `err_ack`. Only reset clears `err_ack`.
- A requester dropping its request while BUSY is illegal. The transaction still completes and the pulse is still generated.
- Reset values: state `IDLE`; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` all 0; counter 0; `err_ack` 0. The valid outputs are 0 because the state is `IDLE`.
- Reset mid-transaction abandons the transaction with no valid pulse. The memory is reset by the same `reset`.

## Timing
- Request sampled in `IDLE` at edge N: `mem_req` is high in cycle N+1. With ack in N+1, `x_valid` is high in N+1 and the FSM is `IDLE` in N+2.
- Minimum occupancy: 2 cycles per access. A requester presenting its next request in N+2 can be granted at edge N+2.
- Each additional wait cycle of memory adds exactly one cycle of stall.
- A request arriving while BUSY is arbitrated in the first `IDLE` cycle. No request is ever accepted in the ack cycle.
- Combinational paths are limited to `mem_ack`/`mem_rdata` → `x_valid`/`x_rdata`/`x_stall`, and `x_req` → `x_stall`. The `mem_*` outputs are registered.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_BUSY_IF`, `ARB_BUSY_DM`}.
  - `grant_t` enum {`GNT_NONE`, `GNT_IF`, `GNT_DM`}.
- Sub-module `arb_starve_cnt`: saturating counter with inputs clear, inc and limit, and output `at_limit`.
- The top level holds the FSM, the request-capture registers and the output mux.

## Test plan
- IF only, `if_addr`=0x100, memory ack 1 cycle after `mem_req` → `mem_addr`=0x100 in N+1, `if_valid` pulse in N+1, `if_stall` low after the pulse.
- Both requesting in the same cycle, IF `if_addr`=0x40, DM store `dm_addr`=0x2000, `dm_wdata`=0xDEADBEEF, `dm_be`=0xF → DM granted first with `mem_we`=1; IF is granted in the `IDLE` cycle after `dm_valid`.
- `dm_req` continuously high with `if_req` waiting, STARVE_LIM=4 → exactly 4 DM grants, then 1 IF grant, then the counter is 0.
- Load with 3 wait cycles, `mem_rdata`=0x12345678 on ack → `dm_stall` high for 4 cycles; `dm_rdata`=0x12345678 when `dm_valid` is high; `mem_addr` stable throughout.
- Stray `mem_ack` in `IDLE` → `err_ack`=1 and stays 1, no valid pulse. Then assert `reset` during `BUSY_IF` → `mem_req`=0, `err_ack`=0, state `IDLE`, no `if_valid` pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types for the unified memory-port arbiter of the RV32I core.
//   arb_state_t : arbiter FSM states (idle, serving fetch, serving data)
//   grant_t     : arbitration decision taken in the idle state
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
// Saturating run-length counter of DM grants taken while IF is waiting.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear_i      : return the count to zero (wins over inc_i)
//   inc_i        : count one more grant, saturating at limit_i
//   limit_i      : saturation value
//   at_limit_o   : registered flag, count has reached limit_i
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit_q, at_limit_d;

  // Next count: clear has priority, increment saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    at_limit_d = (cnt_d >= limit_i);
  end

  // Count and limit-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= {CNT_W{1'b0}};
      at_limit_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign at_limit_o = at_limit_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data memory (DM).
// DM has fixed priority; after STARVE_LIM consecutive DM grants with IF
// waiting, IF is forced through. One transaction outstanding at a time.
// Ports:
//   clk, reset                          : clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_valid/if_stall   : fetch side
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata
//                  -> dm_rdata/dm_valid/dm_stall   : data side
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata (registered), mem_ack/mem_rdata
//                                                  : memory side
//   err_ack                             : sticky, ack seen with nothing pending
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIM);

  arb_state_t        state_q, state_d;
  grant_t            grant_s;
  logic              if_valid_s, dm_valid_s;
  logic              at_limit_s, cnt_clr_s, cnt_inc_s;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_ack_q, err_ack_d;

  // Arbitration and completion: grants only from IDLE, so no request is
  // accepted in an ack cycle.
  always_comb begin
    state_d    = state_q;
    grant_s    = GNT_NONE;
    if_valid_s = 1'b0;
    dm_valid_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dm_req && !at_limit_s) begin
          grant_s = GNT_DM;
          state_d = ARB_BUSY_DM;
        end else if (if_req) begin
          grant_s = GNT_IF;
          state_d = ARB_BUSY_IF;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_IF: begin
        if (mem_ack) begin
          if_valid_s = 1'b1;
          state_d    = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_DM: begin
        if (mem_ack) begin
          dm_valid_s = 1'b1;
          state_d    = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY_DM;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Starvation run only grows while IF is actually waiting behind DM.
  always_comb begin
    cnt_inc_s = (grant_s == GNT_DM) && if_req;
    cnt_clr_s = (grant_s == GNT_IF) || ((grant_s == GNT_DM) && !if_req);
  end

  arb_starve_cnt #(
    .CNT_W(CNT_W)
  ) u_starve_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clr_s),
    .inc_i     (cnt_inc_s),
    .limit_i   (LIMIT),
    .at_limit_o(at_limit_s)
  );

  // Memory-port capture: fields are frozen from grant until the ack.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (grant_s)
      GNT_IF: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_be_d    = {BE_W{1'b1}};
        mem_addr_d  = if_addr;
        mem_wdata_d = {DATA_W{1'b0}};
      end
      GNT_DM: begin
        mem_req_d   = 1'b1;
        mem_we_d    = dm_we;
        mem_be_d    = dm_be;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
      end
      GNT_NONE: begin
        if ((state_q != ARB_IDLE) && mem_ack) begin
          mem_req_d = 1'b0;
        end else begin
          mem_req_d = mem_req_q;
        end
      end
      default: begin
        mem_req_d = mem_req_q;
      end
    endcase
    err_ack_d = err_ack_q | ((state_q == ARB_IDLE) && mem_ack);
  end

  // State, memory-port and error-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= {BE_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      err_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_ack_q   <= err_ack_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_ack   = err_ack_q;

  // Read data is a pass-through; it is only meaningful alongside a valid.
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_valid = if_valid_s;
  assign dm_valid = dm_valid_s;
  assign if_stall = if_req & ~if_valid_s;
  assign dm_stall = dm_req & ~dm_valid_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a transaction-level model of the port (owner, starvation run).
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, err_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, what it asked for, starvation run.
  int          owner;      // 0 none, 1 IF, 2 DM
  int          cnt;
  int          wait_ctr;
  int          fixed_wait; // <0: random latency
  logic        e_err;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  int          glog[$];
  int          gcyc[$];
  int          cyc = 0;
  logic        seen_if, seen_dm;
  int          stall_cnt;
  logic        manual_en, manual_ack;
  logic        rd_ovr_en;
  logic [31:0] rd_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; cnt = 0; e_err = 1'b0; wait_ctr = 0;
  endtask

  task automatic tick();
    logic e_if_v, e_dm_v;
    @(negedge clk);
    e_if_v = (owner == 1) && mem_ack;
    e_dm_v = (owner == 2) && mem_ack;
    chk("if_valid", if_valid, e_if_v);
    chk("dm_valid", dm_valid, e_dm_v);
    chk("if_stall", if_stall, if_req & ~e_if_v);
    chk("dm_stall", dm_stall, dm_req & ~e_dm_v);
    chk("mem_req", mem_req, owner != 0);
    chk("err_ack", err_ack, e_err);
    if (owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (owner == 2) begin
        chk("mem_be", mem_be, m_be);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (e_if_v) chk("if_rdata", if_rdata, mem_rdata);
    if (e_dm_v && !m_we) chk("dm_rdata", dm_rdata, mem_rdata);
    seen_if = e_if_v;
    seen_dm = e_dm_v;
    if (dm_stall) stall_cnt++;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else if (owner == 0) begin
      if (mem_ack) e_err = 1'b1;
      if (dm_req && cnt < LIM) begin
        owner = 2; m_addr = dm_addr; m_we = dm_we; m_be = dm_be; m_wdata = dm_wdata;
        cnt = if_req ? cnt + 1 : 0;
      end else if (if_req) begin
        owner = 1; m_addr = if_addr; m_we = 1'b0; cnt = 0;
      end
      if (owner != 0) begin
        glog.push_back(owner);
        gcyc.push_back(cyc);
        wait_ctr = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
    end else if (mem_ack) begin
      owner = 0;
    end else begin
      wait_ctr--;
    end
    #1;
    mem_rdata = rd_ovr_en ? rd_ovr : $urandom;
    mem_ack   = manual_en ? manual_ack : ((owner != 0) && (wait_ctr == 0));
  endtask

  task automatic drop_done();
    if (seen_if) if_req = 1'b0;
    if (seen_dm) dm_req = 1'b0;
  endtask

  task automatic rand_drive();
    if (if_req) begin
      if (seen_if) begin
        if_req  = ($urandom_range(0, 1) == 1);
        if_addr = $urandom;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = $urandom;
    end
    if (dm_req) begin
      if (seen_dm) begin
        dm_req = ($urandom_range(0, 1) == 1);
        dm_we = 1'($urandom_range(0, 1)); dm_be = 4'($urandom_range(0, 15));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      dm_req = 1'b1;
      dm_we = 1'($urandom_range(0, 1)); dm_be = 4'($urandom_range(0, 15));
      dm_addr = $urandom; dm_wdata = $urandom;
    end
  endtask

  initial begin
    int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    int n;
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0;
    dm_be = 4'd0; dm_addr = 32'd0; dm_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    manual_en = 1'b0; manual_ack = 1'b0; rd_ovr_en = 1'b0; rd_ovr = 32'd0;
    fixed_wait = 0; seen_if = 1'b0; seen_dm = 1'b0; stall_cnt = 0;
    m_addr = 32'd0; m_wdata = 32'd0; m_we = 1'b0; m_be = 4'd0;
    model_reset();
    tick(); tick();
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_be", mem_be, 4'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // IF only, ack one cycle after mem_req.
    glog.delete(); gcyc.delete();
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    chk("t1_if_valid_seen", seen_if, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    drop_done();
    tick();
    chk("t1_grants", glog.size(), 1);

    // Simultaneous IF fetch and DM store.
    glog.delete(); gcyc.delete();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
    n = 0;
    while (!(glog.size() >= 2 && seen_if) && n < 50) begin tick(); drop_done(); n++; end
    chk("t2_timeout", n < 50, 1'b1);
    if (glog.size() >= 2) begin
      chk("t2_first", glog[0], 2);
      chk("t2_second", glog[1], 1);
      chk("t2_gap", gcyc[1] - gcyc[0], 2);
    end
    tick();

    // Starvation guard with DM hammering.
    glog.delete(); gcyc.delete();
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_be = 4'hF;
    n = 0;
    while (glog.size() < 10 && n < 200) begin tick(); n++; end
    chk("t3_timeout", n < 200, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < glog.size()) chk($sformatf("t3_grant%0d", i), glog[i], exp_seq[i]);
    end
    n = 0;
    while (!seen_if && n < 20) begin tick(); n++; end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();

    // Load with three wait cycles.
    fixed_wait = 3; rd_ovr_en = 1'b1; rd_ovr = 32'h12345678;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4444; dm_be = 4'hF;
    stall_cnt = 0; n = 0;
    tick();
    while (!seen_dm && n < 20) begin tick(); n++; end
    chk("t4_dm_done", seen_dm, 1'b1);
    chk("t4_stall_cycles", stall_cnt, 4);
    chk("t4_rdata", dm_rdata, 32'h12345678);
    dm_req = 1'b0; rd_ovr_en = 1'b0; fixed_wait = 0;
    tick();

    // Stray ack in IDLE, then reset during BUSY_IF.
    manual_en = 1'b1; manual_ack = 1'b1; mem_ack = 1'b1;
    tick();
    manual_ack = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    chk("t5_err_sticky", err_ack, 1'b1);
    manual_en = 1'b0;
    fixed_wait = 10;
    if_req = 1'b1; if_addr = 32'h880;
    tick(); tick();
    chk("t5_busy", mem_req, 1'b1);
    reset = 1'b1; mem_ack = 1'b0;
    model_reset();
    tick();
    chk("t5_rst_mem_req", mem_req, 1'b0);
    chk("t5_rst_err", err_ack, 1'b0);
    reset = 1'b0; if_req = 1'b0; fixed_wait = -1;
    tick(); tick();

    // Randomized traffic with random memory latency.
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      tick();
    end
    n = 0;
    while (owner != 0 && n < 20) begin tick(); n++; end
    if_req = 1'b0; dm_req = 1'b0;
    n = 0;
    while (owner != 0 && n < 20) begin tick(); n++; end
    chk("end_idle", mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
